// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and helpers for the truth-table sequencer.
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_e;

  // Number of input vectors swept for an n_in-input function unit.
  function automatic int unsigned tt_vectors(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle down-counter: load SETTLE-1, count down while enabled, expired at zero.
module tt_settle_timer #(
  parameter int unsigned SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a combinational unit, captures its outputs into a
// packed truth table and compares against a golden table.
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned N_OUT  = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic [N_IN-1:0]            vec,
  input  logic [N_OUT-1:0]           fout,
  input  logic [N_OUT*(2**N_IN)-1:0] expected,
  output logic [N_OUT*(2**N_IN)-1:0] table_o,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [N_IN-1:0]            fail_idx,
  output logic [N_IN:0]              err_cnt
);

  localparam int unsigned NV = tt_vectors(N_IN);

  tt_state_e                     state_q, state_d;
  logic [N_IN-1:0]               vec_q, vec_d;
  logic [N_OUT-1:0][NV-1:0]      table_q, table_d;
  logic                          busy_q, busy_d;
  logic                          done_q, done_d;
  logic                          pass_q, pass_d;
  logic [N_IN-1:0]               fail_idx_q, fail_idx_d;
  logic [N_IN:0]                 err_cnt_q, err_cnt_d;

  logic [N_OUT-1:0][NV-1:0]      exp_2d;
  logic [N_OUT-1:0][NV-1:0]      cap_2d;
  logic [N_OUT-1:0]              mis;
  logic                          timer_load;
  logic                          timer_expired;

  // Packed [o][i] view lands bit (o,i) at flat position o*2^N_IN+i.
  assign exp_2d = expected;

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    assign cap_2d[o] = (table_q[o] & ~(NV'(1) << vec_q)) | (NV'(fout[o]) << vec_q);
    assign mis[o]    = (fout[o] !== exp_2d[o][vec_q]);
  end

  tt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (timer_load),
    .en     (state_q == ST_DRIVE),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    table_d    = table_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    fail_idx_d = fail_idx_q;
    err_cnt_d  = err_cnt_q;
    timer_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_DRIVE;
          vec_d      = '0;
          table_d    = '0;
          pass_d     = 1'b0;
          fail_idx_d = '0;
          err_cnt_d  = '0;
          busy_d     = 1'b1;
          timer_load = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (timer_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        table_d = cap_2d;
        if (|mis) begin
          err_cnt_d = err_cnt_q + (N_IN+1)'(1);
          if (err_cnt_q == '0) begin
            fail_idx_d = vec_q;
          end
        end
        if (vec_q == '1) begin
          state_d = ST_DONE;
        end else begin
          vec_d      = vec_q + N_IN'(1);
          state_d    = ST_DRIVE;
          timer_load = 1'b1;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_cnt_q == '0);
        vec_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      vec_q      <= '0;
      table_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_idx_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      table_q    <= table_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_idx_q <= fail_idx_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign vec      = vec_q;
  assign table_o  = table_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail_idx = fail_idx_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer driving an fxy unit (s1, s2 both reduce to x|~y).
module tb_truth_table_sequencer;

  localparam int LAT  = 9;   // 4 vectors * (1+1) + 1
  localparam int LAT3 = 17;  // 4 vectors * (3+1) + 1

  logic       clk = 1'b0;
  logic       reset, start, start3;
  logic [1:0] vec, vec3, fout, fout3;
  logic [7:0] expected, expected3, table_o, table3;
  logic       busy, done, pass, busy3, done3, pass3;
  logic [1:0] fail_idx, fail_idx3;
  logic [2:0] err_cnt, err_cnt3;

  int checks = 0;
  int failures = 0;

  logic [1:0] obs_vec [0:LAT];
  logic       obs_busy[0:LAT];
  logic       obs_done[0:LAT];
  logic       obs_pass0;
  logic [7:0] obs_tbl0;
  logic [2:0] obs_err0;

  always #5 clk = ~clk;

  // The function unit under sweep: fout[0]=s1, fout[1]=s2.
  function automatic logic [1:0] fxy(input logic [1:0] v);
    logic x, y;
    x = v[1];
    y = v[0];
    return {x | ~y, ~(~x & y) & (x | ~y)};
  endfunction

  assign fout  = fxy(vec);
  assign fout3 = fxy(vec3);

  truth_table_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(1)) dut (
    .clk(clk), .reset(reset), .start(start), .vec(vec), .fout(fout),
    .expected(expected), .table_o(table_o), .busy(busy), .done(done),
    .pass(pass), .fail_idx(fail_idx), .err_cnt(err_cnt)
  );

  truth_table_sequencer #(.N_IN(2), .N_OUT(2), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .vec(vec3), .fout(fout3),
    .expected(expected3), .table_o(table3), .busy(busy3), .done(done3),
    .pass(pass3), .fail_idx(fail_idx3), .err_cnt(err_cnt3)
  );

  // ---------------- reference model ----------------
  // Function value is 1 except at x=0,y=1 (vector 1); same for both outputs.
  function automatic logic [7:0] ref_table();
    logic [7:0] t;
    t = '0;
    for (int i = 0; i < 4; i++) begin
      if (!((i / 2 == 0) && (i % 2 == 1))) t = t | (8'h11 << i);
    end
    return t;
  endfunction

  function automatic int ref_errs(input logic [7:0] exp);
    int n;
    logic [7:0] d;
    n = 0;
    d = ref_table() ^ exp;
    for (int i = 0; i < 4; i++) if (((d >> i) & 8'h11) != 8'h00) n++;
    return n;
  endfunction

  function automatic int ref_first(input logic [7:0] exp);
    logic [7:0] d;
    d = ref_table() ^ exp;
    for (int i = 0; i < 4; i++) if (((d >> i) & 8'h11) != 8'h00) return i;
    return 0;
  endfunction

  // Vector shown k cycles after start acceptance (SETTLE=1).
  function automatic logic [1:0] ref_vec(input int k);
    if (k >= LAT) return 2'd0;
    if (k / 2 > 3) return 2'd3;
    return 2'(k / 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: one start pulse, record outputs for cycles 0..LAT after acceptance.
  task automatic do_sweep(input logic [7:0] exp);
    expected = exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    obs_pass0 = pass;
    obs_tbl0  = table_o;
    obs_err0  = err_cnt;
    for (int k = 0; k <= LAT; k++) begin
      if (k > 0) tick();
      obs_vec[k]  = vec;
      obs_busy[k] = busy;
      obs_done[k] = done;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start3 = 1'b0;
    expected = 8'h00; expected3 = 8'hDD;
    tick(); tick();
    checks++;
    if ({vec, table_o, busy, done, pass, fail_idx, err_cnt} !== 17'd0) begin
      failures++;
      $display("FAIL reset_outputs: got vec=%0h tbl=%0h busy=%0b done=%0b pass=%0b fidx=%0h err=%0h, need all 0",
               vec, table_o, busy, done, pass, fail_idx, err_cnt);
    end
    checks++;
    if ({busy3, done3, vec3} !== 4'd0) begin
      failures++;
      $display("FAIL reset_dut3: got busy=%0b done=%0b vec=%0h, need 0", busy3, done3, vec3);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_golden();
    do_sweep(8'hDD);
    for (int k = 0; k <= LAT; k++) begin
      checks++;
      if ({obs_vec[k], obs_busy[k], obs_done[k]} !== {ref_vec(k), k < LAT, k == LAT}) begin
        failures++;
        $display("FAIL golden_timing k=%0d: got vec=%0h busy=%0b done=%0b, need vec=%0h busy=%0b done=%0b",
                 k, obs_vec[k], obs_busy[k], obs_done[k], ref_vec(k), k < LAT, k == LAT);
      end
    end
    checks++;
    if ({table_o, pass, err_cnt, fail_idx} !== {ref_table(), 1'b1, 3'd0, 2'd0}) begin
      failures++;
      $display("FAIL golden_result: got tbl=%0h pass=%0b err=%0d fidx=%0d, need tbl=%0h pass=1 err=0 fidx=0",
               table_o, pass, err_cnt, fail_idx, ref_table());
    end
    tick(); tick(); tick();
    checks++;
    if ({pass, done, busy} !== 3'b100) begin
      failures++;
      $display("FAIL golden_hold: got pass=%0b done=%0b busy=%0b, need 1 0 0", pass, done, busy);
    end
  endtask

  task automatic test_single_mismatch();
    do_sweep(8'hDF);
    checks++;
    if ({table_o, pass, fail_idx, err_cnt} !== {8'hDD, 1'b0, 2'd1, 3'd1}) begin
      failures++;
      $display("FAIL single_mismatch: got tbl=%0h pass=%0b fidx=%0d err=%0d, need DD 0 1 1",
               table_o, pass, fail_idx, err_cnt);
    end
  endtask

  task automatic test_all_wrong();
    do_sweep(8'h22);
    checks++;
    if ({table_o, pass, fail_idx, err_cnt} !== {8'hDD, 1'b0, 2'd0, 3'd4}) begin
      failures++;
      $display("FAIL all_wrong: got tbl=%0h pass=%0b fidx=%0d err=%0d, need DD 0 0 4",
               table_o, pass, fail_idx, err_cnt);
    end
  endtask

  task automatic test_random();
    logic [7:0] e;
    for (int n = 0; n < 16; n++) begin
      if (n % 2 == 0) e = 8'hDD ^ (8'($urandom) & 8'($urandom));
      else            e = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      do_sweep(e);
      checks++;
      if ({obs_pass0, obs_tbl0, obs_err0} !== 12'd0) begin
        failures++;
        $display("FAIL rand_clear n=%0d: got pass=%0b tbl=%0h err=%0d at accept, need 0",
                 n, obs_pass0, obs_tbl0, obs_err0);
      end
      checks++;
      if ({obs_done[LAT-1], obs_done[LAT], obs_busy[LAT-1], obs_busy[LAT]} !== 4'b0110) begin
        failures++;
        $display("FAIL rand_latency n=%0d: got done@8,9=%0b%0b busy@8,9=%0b%0b, need 01 10",
                 n, obs_done[LAT-1], obs_done[LAT], obs_busy[LAT-1], obs_busy[LAT]);
      end
      checks++;
      if ({table_o, pass, fail_idx, err_cnt} !==
          {ref_table(), ref_errs(e) == 0, 2'(ref_first(e)), 3'(ref_errs(e))}) begin
        failures++;
        $display("FAIL rand_result n=%0d exp=%0h: got tbl=%0h pass=%0b fidx=%0d err=%0d, need tbl=%0h pass=%0b fidx=%0d err=%0d",
                 n, e, table_o, pass, fail_idx, err_cnt, ref_table(), ref_errs(e) == 0,
                 ref_first(e), ref_errs(e));
      end
    end
  endtask

  task automatic test_start_ignored();
    int ndone;
    ndone = 0;
    tick();
    expected = 8'hDD;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      start = (k == 3) || (k == 9);
      tick();
      start = 1'b0;
      if (done) ndone++;
      checks++;
      if ({busy, done} !== {k < LAT, k == LAT}) begin
        failures++;
        $display("FAIL start_ignored k=%0d: got busy=%0b done=%0b, need busy=%0b done=%0b",
                 k, busy, done, k < LAT, k == LAT);
      end
    end
    checks++;
    if (ndone !== 1) begin
      failures++;
      $display("FAIL start_ignored_count: got %0d done pulses, need 1", ndone);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int ndone;
    ndone = 0;
    expected = 8'hDD;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (vec !== 2'd2) begin
      failures++;
      $display("FAIL midreset_pre: got vec=%0d, need 2", vec);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if ({busy, vec, table_o, done, pass, err_cnt, fail_idx} !== 17'd0) begin
      failures++;
      $display("FAIL midreset_clear: got busy=%0b vec=%0h tbl=%0h done=%0b pass=%0b err=%0d fidx=%0d, need 0",
               busy, vec, table_o, done, pass, err_cnt, fail_idx);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      failures++;
      $display("FAIL midreset_quiet: got %0d busy/done cycles after abort, need 0", ndone);
    end
    do_sweep(8'hDD);
    checks++;
    if ({obs_done[LAT], pass, table_o} !== {1'b1, 1'b1, 8'hDD}) begin
      failures++;
      $display("FAIL midreset_resweep: got done=%0b pass=%0b tbl=%0h, need 1 1 DD",
               obs_done[LAT], pass, table_o);
    end
  endtask

  task automatic test_back_to_back();
    int dq[$];
    int bad;
    bad = 0;
    start3 = 1'b1;
    tick();
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (done3) begin
        dq.push_back(c);
        if (!pass3 || table3 !== ref_table() || err_cnt3 !== 3'd0) bad++;
      end
    end
    start3 = 1'b0;
    checks++;
    if (dq.size() !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d done pulses, need 3", dq.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (dq[j] !== LAT3 + j * (LAT3 + 1)) begin
          failures++;
          $display("FAIL b2b_spacing j=%0d: got done at cycle %0d, need %0d", j, dq[j], LAT3 + j * (LAT3 + 1));
        end
      end
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL b2b_result: got %0d sweeps with wrong pass/table/err, need 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_single_mismatch();
    test_all_wrong();
    test_random();
    test_start_ignored();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
